// File: rtl/memory_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// memory_arbiter_pkg
//   Shared types for the unified memory port arbiter.
//   - MemoryWriteSignal : read/write function code carried on the memory port
//   - MemoryMaskType    : access width / sign-extension selector
//   - ArbState          : arbiter sequencing states
//   - ArbOwner          : which requester owns the outstanding transaction
// ---------------------------------------------------------------------------
package memory_arbiter_pkg;

    typedef enum logic {
        M_XRD = 1'b0,
        M_XWR = 1'b1
    } MemoryWriteSignal;

    typedef enum logic [2:0] {
        MT_X  = 3'd0,
        MT_B  = 3'd1,
        MT_H  = 3'd2,
        MT_W  = 3'd3,
        MT_BU = 3'd4,
        MT_HU = 3'd5
    } MemoryMaskType;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_ISSUE,
        ARB_WAIT
    } ArbState;

    typedef enum logic {
        OWN_IMEM,
        OWN_DMEM
    } ArbOwner;

    // Width of the per-transaction timeout counter.
    localparam int WAIT_CNT_W = 16;

endpackage

// File: rtl/memory_arbiter.sv
// ---------------------------------------------------------------------------
// memory_arbiter
//   Shares one variable-latency memory port between instruction fetch (imem)
//   and the data stage (dmem). One transaction is outstanding at a time; the
//   response is routed back to whichever requester issued it.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   imem_req_* / imem_kill      fetch request, kill of pending/in-flight fetch
//   imem_resp_*                 one-cycle fetch response
//   dmem_req_*                  data request (addr, fcn, typ, store data)
//   dmem_resp_*                 one-cycle data response
//   mem_req_* / mem_resp_*      external memory request/response
//   cmiss_stall                 a requester is waiting (combinational)
//   bus_error                   sticky timeout flag
// ---------------------------------------------------------------------------
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        imem_req_valid,
    input  logic [31:0] imem_req_addr,
    input  logic        imem_kill,
    output logic        imem_resp_valid,
    output logic [31:0] imem_resp_data,
    input  logic        dmem_req_valid,
    input  logic [31:0] dmem_req_addr,
    input  logic        dmem_req_fcn,
    input  logic [2:0]  dmem_req_typ,
    input  logic [31:0] dmem_req_data,
    output logic        dmem_resp_valid,
    output logic [31:0] dmem_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output logic [31:0] mem_req_addr,
    output logic        mem_req_fcn,
    output logic [2:0]  mem_req_typ,
    output logic [31:0] mem_req_data,
    input  logic        mem_resp_valid,
    input  logic [31:0] mem_resp_data,
    output logic        cmiss_stall,
    output logic        bus_error
);

    localparam logic [WAIT_CNT_W-1:0] TIMEOUT_LAST = WAIT_CNT_W'(TIMEOUT_CYCLES - 1);

    ArbState                 state_reg;
    ArbOwner                 owner_reg;
    ArbOwner                 last_owner_reg;
    logic                    killed_reg;
    logic [WAIT_CNT_W-1:0]   wait_cnt_reg;
    logic [31:0]             addr_reg;
    MemoryWriteSignal        fcn_reg;
    MemoryMaskType           typ_reg;
    logic [31:0]             data_reg;
    logic                    bus_error_reg;

    // A fetch being killed this cycle is not eligible for a grant.
    logic imem_cand;
    logic grant_any;
    logic grant_dmem;
    logic busy;
    logic resp_hit;
    logic timeout_hit;
    logic complete;
    logic imem_dropped;

    assign imem_cand  = imem_req_valid & ~imem_kill;
    assign grant_any  = imem_cand | dmem_req_valid;
    // On contention the requester that did not win last time is served.
    assign grant_dmem = dmem_req_valid & (~imem_cand | (last_owner_reg == OWN_IMEM));

    assign busy        = (state_reg == ARB_ISSUE) | (state_reg == ARB_WAIT);
    assign resp_hit    = (state_reg == ARB_WAIT) & mem_resp_valid;
    // A real response in the last allowed cycle wins over the timeout.
    assign timeout_hit = busy & (wait_cnt_reg == TIMEOUT_LAST) & ~resp_hit;
    assign complete    = resp_hit | timeout_hit;

    // A kill arriving in the completion cycle also suppresses the strobe.
    assign imem_dropped = killed_reg | imem_kill;

    assign imem_resp_valid = complete & (owner_reg == OWN_IMEM) & ~imem_dropped;
    assign dmem_resp_valid = complete & (owner_reg == OWN_DMEM);
    assign imem_resp_data  = resp_hit ? mem_resp_data : 32'h0;
    assign dmem_resp_data  = resp_hit ? mem_resp_data : 32'h0;

    assign mem_req_valid = (state_reg == ARB_ISSUE);
    assign mem_req_addr  = addr_reg;
    assign mem_req_fcn   = fcn_reg;
    assign mem_req_typ   = typ_reg;
    assign mem_req_data  = data_reg;
    assign bus_error     = bus_error_reg;

    assign cmiss_stall = (imem_req_valid & ~imem_resp_valid) |
                         (dmem_req_valid & ~dmem_resp_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= ARB_IDLE;
            owner_reg      <= OWN_IMEM;
            last_owner_reg <= OWN_IMEM;
            killed_reg     <= 1'b0;
            wait_cnt_reg   <= '0;
            addr_reg       <= '0;
            fcn_reg        <= M_XRD;
            typ_reg        <= MT_X;
            data_reg       <= '0;
            bus_error_reg  <= 1'b0;
        end else begin
            case (state_reg)
                ARB_IDLE: begin
                    if (grant_any) begin
                        owner_reg      <= grant_dmem ? OWN_DMEM : OWN_IMEM;
                        last_owner_reg <= grant_dmem ? OWN_DMEM : OWN_IMEM;
                        killed_reg     <= 1'b0;
                        wait_cnt_reg   <= '0;
                        state_reg      <= ARB_ISSUE;
                        if (grant_dmem) begin
                            addr_reg <= dmem_req_addr;
                            fcn_reg  <= MemoryWriteSignal'(dmem_req_fcn);
                            typ_reg  <= MemoryMaskType'(dmem_req_typ);
                            data_reg <= dmem_req_data;
                        end else begin
                            // Fetches are always full-word reads.
                            addr_reg <= imem_req_addr;
                            fcn_reg  <= M_XRD;
                            typ_reg  <= MT_W;
                            data_reg <= '0;
                        end
                    end
                end
                ARB_ISSUE, ARB_WAIT: begin
                    wait_cnt_reg <= wait_cnt_reg + WAIT_CNT_W'(1);
                    if (imem_kill && owner_reg == OWN_IMEM) begin
                        killed_reg <= 1'b1;
                    end
                    if (complete) begin
                        state_reg <= ARB_IDLE;
                        if (timeout_hit) begin
                            bus_error_reg <= 1'b1;
                        end
                    end else if (state_reg == ARB_ISSUE && mem_req_ready) begin
                        state_reg <= ARB_WAIT;
                    end
                end
                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// ---------------------------------------------------------------------------
// tb_memory_arbiter
//   Directed bench for memory_arbiter. The main instance (timeout 8) is
//   tracked every cycle by a transaction-level model; a second instance with
//   timeout 4 shares the stimulus and is pinned with literal expectations in
//   the timeout scenario.
// ---------------------------------------------------------------------------
module tb_memory_arbiter;

    localparam int TO_MAIN  = 8;
    localparam int TO_SHORT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_kill;
    logic        dmem_req_valid;
    logic [31:0] dmem_req_addr;
    logic        dmem_req_fcn;
    logic [2:0]  dmem_req_typ;
    logic [31:0] dmem_req_data;
    logic        mem_req_ready;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_data;

    logic        imem_resp_valid, dmem_resp_valid, mem_req_valid;
    logic [31:0] imem_resp_data, dmem_resp_data, mem_req_addr, mem_req_data;
    logic        mem_req_fcn, cmiss_stall, bus_error;
    logic [2:0]  mem_req_typ;

    logic        t_imem_resp_valid, t_dmem_resp_valid, t_mem_req_valid;
    logic [31:0] t_imem_resp_data, t_dmem_resp_data, t_mem_req_addr, t_mem_req_data;
    logic        t_mem_req_fcn, t_cmiss_stall, t_bus_error;
    logic [2:0]  t_mem_req_typ;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    memory_arbiter #(.TIMEOUT_CYCLES(TO_MAIN)) dut (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_kill(imem_kill),
        .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
        .dmem_req_fcn(dmem_req_fcn), .dmem_req_typ(dmem_req_typ), .dmem_req_data(dmem_req_data),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_fcn(mem_req_fcn), .mem_req_typ(mem_req_typ),
        .mem_req_data(mem_req_data), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .cmiss_stall(cmiss_stall), .bus_error(bus_error)
    );

    memory_arbiter #(.TIMEOUT_CYCLES(TO_SHORT)) u_to (
        .clk(clk), .reset(reset),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_kill(imem_kill),
        .imem_resp_valid(t_imem_resp_valid), .imem_resp_data(t_imem_resp_data),
        .dmem_req_valid(dmem_req_valid), .dmem_req_addr(dmem_req_addr),
        .dmem_req_fcn(dmem_req_fcn), .dmem_req_typ(dmem_req_typ), .dmem_req_data(dmem_req_data),
        .dmem_resp_valid(t_dmem_resp_valid), .dmem_resp_data(t_dmem_resp_data),
        .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(t_mem_req_addr), .mem_req_fcn(t_mem_req_fcn), .mem_req_typ(t_mem_req_typ),
        .mem_req_data(t_mem_req_data), .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data),
        .cmiss_stall(t_cmiss_stall), .bus_error(t_bus_error)
    );

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- transaction-level model of the main instance ----------
    bit          m_ok = 0;
    bit          m_txn, m_dmem, m_acc, m_kill, m_prefer_imem, m_berr;
    int          m_age;
    logic [31:0] m_addr, m_data;
    logic        m_fcn;
    logic [2:0]  m_typ;

    always @(negedge clk) begin
        bit arrive, tmo, done, dropped, e_iv, e_dv, e_stall, iv, pick_d;
        if (m_ok) begin
            arrive  = m_txn && m_acc && mem_resp_valid;
            tmo     = m_txn && (m_age == TO_MAIN - 1) && !arrive;
            done    = arrive || tmo;
            dropped = m_kill || (imem_kill && !m_dmem);
            e_iv    = done && !m_dmem && !dropped;
            e_dv    = done && m_dmem;
            e_stall = (imem_req_valid && !e_iv) || (dmem_req_valid && !e_dv);

            chk1("model_mem_req_valid", mem_req_valid, m_txn && !m_acc);
            if (m_txn && !m_acc) begin
                chk32("model_mem_req_addr", mem_req_addr, m_addr);
                chk1("model_mem_req_fcn", mem_req_fcn, m_fcn);
                if (m_dmem) begin
                    chk32("model_mem_req_typ", {29'b0, mem_req_typ}, {29'b0, m_typ});
                    chk32("model_mem_req_data", mem_req_data, m_data);
                end
            end
            chk1("model_imem_resp_valid", imem_resp_valid, e_iv);
            chk1("model_dmem_resp_valid", dmem_resp_valid, e_dv);
            chk1("model_cmiss_stall", cmiss_stall, e_stall);
            chk1("model_bus_error", bus_error, m_berr);
            if (e_iv) chk32("model_imem_resp_data", imem_resp_data, arrive ? mem_resp_data : 32'h0);
            if (e_dv) chk32("model_dmem_resp_data", dmem_resp_data, arrive ? mem_resp_data : 32'h0);
            if (done)
                $display("txn %0s addr=%h %0s data=%h delivered=%0d", m_dmem ? "dmem" : "imem",
                         m_addr, tmo ? "timeout" : "resp", arrive ? mem_resp_data : 32'h0,
                         e_iv || e_dv);
        end

        if (reset) begin
            m_txn = 0; m_dmem = 0; m_acc = 0; m_kill = 0; m_age = 0;
            m_prefer_imem = 0; m_berr = 0;
            m_addr = '0; m_data = '0; m_fcn = 1'b0; m_typ = '0;
            m_ok = 1;
        end else if (m_ok) begin
            if (m_txn) begin
                if (done) begin
                    m_txn = 0;
                    if (tmo) m_berr = 1;
                end else begin
                    if (!m_acc && mem_req_ready) m_acc = 1;
                    m_age++;
                    if (imem_kill && !m_dmem) m_kill = 1;
                end
            end else begin
                iv = imem_req_valid && !imem_kill;
                if (iv || dmem_req_valid) begin
                    pick_d = dmem_req_valid && (!iv || !m_prefer_imem);
                    m_txn = 1; m_acc = 0; m_kill = 0; m_age = 0; m_dmem = pick_d;
                    m_prefer_imem = pick_d;
                    if (pick_d) begin
                        m_addr = dmem_req_addr; m_fcn = dmem_req_fcn;
                        m_typ = dmem_req_typ; m_data = dmem_req_data;
                    end else begin
                        m_addr = imem_req_addr; m_fcn = 1'b0;
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- directed stimulus ------------------------------------
    initial begin
        reset = 1; imem_req_valid = 0; imem_req_addr = 0; imem_kill = 0;
        dmem_req_valid = 0; dmem_req_addr = 0; dmem_req_fcn = 0; dmem_req_typ = 0;
        dmem_req_data = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_data = 0;
        tick(); tick();
        reset = 0;
        @(negedge clk);
        chk1("rst_mem_req_valid", mem_req_valid, 1'b0);
        chk1("rst_imem_resp_valid", imem_resp_valid, 1'b0);
        chk1("rst_dmem_resp_valid", dmem_resp_valid, 1'b0);
        chk1("rst_bus_error", bus_error, 1'b0);
        chk1("rst_cmiss_stall", cmiss_stall, 1'b0);
        chk32("rst_mem_req_addr", mem_req_addr, 32'h0);

        // Single fetch
        tick(); imem_req_valid = 1; imem_req_addr = 32'h100;
        @(negedge clk); chk1("fetch_stall_t0", cmiss_stall, 1'b1); chk1("fetch_reqv_t0", mem_req_valid, 1'b0);
        tick(); mem_req_ready = 1;
        @(negedge clk); chk1("fetch_reqv_t1", mem_req_valid, 1'b1); chk32("fetch_addr_t1", mem_req_addr, 32'h100);
        tick(); mem_req_ready = 0;
        @(negedge clk); chk1("fetch_stall_t2", cmiss_stall, 1'b1); chk1("fetch_respv_t2", imem_resp_valid, 1'b0);
        tick(); mem_resp_valid = 1; mem_resp_data = 32'hDEADBEEF;
        @(negedge clk); chk1("fetch_respv_t3", imem_resp_valid, 1'b1);
        chk32("fetch_data_t3", imem_resp_data, 32'hDEADBEEF); chk1("fetch_stall_t3", cmiss_stall, 1'b0);
        tick(); mem_resp_valid = 0; imem_req_valid = 0;
        @(negedge clk); chk1("fetch_respv_t4", imem_resp_valid, 1'b0);

        // Contention after reset: dmem first, then imem, then dmem again
        tick(); reset = 1;
        tick(); reset = 0;
        imem_req_valid = 1; imem_req_addr = 32'h200;
        dmem_req_valid = 1; dmem_req_addr = 32'h400; dmem_req_fcn = 0; dmem_req_typ = 3'd3;
        tick(); mem_req_ready = 1;
        @(negedge clk); chk32("cont1_addr", mem_req_addr, 32'h400); chk1("cont1_fcn", mem_req_fcn, 1'b0);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hA0A00400;
        @(negedge clk); chk1("cont1_dresp", dmem_resp_valid, 1'b1); chk1("cont1_iresp", imem_resp_valid, 1'b0);
        chk32("cont1_ddata", dmem_resp_data, 32'hA0A00400);
        tick(); mem_resp_valid = 0; dmem_req_valid = 0;
        tick(); mem_req_ready = 1;
        @(negedge clk); chk32("cont2_addr", mem_req_addr, 32'h200);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hB0B00200;
        @(negedge clk); chk1("cont2_iresp", imem_resp_valid, 1'b1); chk32("cont2_idata", imem_resp_data, 32'hB0B00200);
        tick(); mem_resp_valid = 0; dmem_req_valid = 1; dmem_req_addr = 32'h404;
        tick(); mem_req_ready = 1;
        @(negedge clk); chk32("cont3_addr", mem_req_addr, 32'h404);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hC0C00404;
        @(negedge clk); chk1("cont3_dresp", dmem_resp_valid, 1'b1);
        tick(); mem_resp_valid = 0; dmem_req_valid = 0;
        tick(); mem_req_ready = 1;
        @(negedge clk); chk32("cont4_addr", mem_req_addr, 32'h200);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'hD0D00200;
        @(negedge clk); chk1("cont4_iresp", imem_resp_valid, 1'b1);
        tick(); mem_resp_valid = 0; imem_req_valid = 0;

        // Store passthrough held across three not-ready cycles
        dmem_req_valid = 1; dmem_req_addr = 32'h10; dmem_req_fcn = 1; dmem_req_typ = 3'd3;
        dmem_req_data = 32'h1234;
        for (int i = 0; i < 3; i++) begin
            tick();
            @(negedge clk);
            chk1("store_reqv", mem_req_valid, 1'b1); chk32("store_addr", mem_req_addr, 32'h10);
            chk1("store_fcn", mem_req_fcn, 1'b1); chk32("store_typ", {29'b0, mem_req_typ}, 32'd3);
            chk32("store_data", mem_req_data, 32'h1234);
        end
        tick(); mem_req_ready = 1;
        @(negedge clk); chk1("store_reqv_ready", mem_req_valid, 1'b1);
        tick(); mem_req_ready = 0;
        @(negedge clk); chk1("store_reqv_wait", mem_req_valid, 1'b0);
        tick(); mem_resp_valid = 1; mem_resp_data = 32'h0;
        @(negedge clk); chk1("store_dresp", dmem_resp_valid, 1'b1);
        tick(); mem_resp_valid = 0; dmem_req_valid = 0; dmem_req_fcn = 0; dmem_req_data = 0;

        // Kill in IDLE suppresses the grant; kill in WAIT drops the response
        imem_req_valid = 1; imem_req_addr = 32'h300; imem_kill = 1;
        tick(); imem_kill = 0;
        @(negedge clk); chk1("kill_idle_reqv", mem_req_valid, 1'b0);
        tick(); mem_req_ready = 1;
        @(negedge clk); chk1("kill_reqv", mem_req_valid, 1'b1); chk32("kill_addr", mem_req_addr, 32'h300);
        tick(); mem_req_ready = 0; imem_kill = 1; imem_req_valid = 0;
        @(negedge clk); chk1("kill_wait_iresp", imem_resp_valid, 1'b0);
        tick(); imem_kill = 0; mem_resp_valid = 1; mem_resp_data = 32'h3333;
        @(negedge clk); chk1("kill_resp_iresp", imem_resp_valid, 1'b0);
        tick(); mem_resp_valid = 0; imem_req_valid = 1; imem_req_addr = 32'h304;
        tick(); mem_req_ready = 1;
        @(negedge clk); chk32("after_kill_addr", mem_req_addr, 32'h304);
        tick(); mem_req_ready = 0; mem_resp_valid = 1; mem_resp_data = 32'h4444;
        @(negedge clk); chk1("after_kill_iresp", imem_resp_valid, 1'b1);
        chk32("after_kill_data", imem_resp_data, 32'h4444);
        tick(); mem_resp_valid = 0; imem_req_valid = 0;

        // Timeout: ready never comes
        tick(); reset = 1;
        tick(); reset = 0; dmem_req_valid = 1; dmem_req_addr = 32'h40; dmem_req_typ = 3'd3;
        tick();
        @(negedge clk); chk1("to_reqv", t_mem_req_valid, 1'b1); chk1("to_dresp_1", t_dmem_resp_valid, 1'b0);
        tick(); @(negedge clk); chk1("to_dresp_2", t_dmem_resp_valid, 1'b0);
        tick(); @(negedge clk); chk1("to_dresp_3", t_dmem_resp_valid, 1'b0);
        tick();
        @(negedge clk); chk1("to_dresp_4", t_dmem_resp_valid, 1'b1);
        chk32("to_ddata", t_dmem_resp_data, 32'h0); chk1("to_berr_4", t_bus_error, 1'b0);
        tick(); dmem_req_valid = 0;
        @(negedge clk); chk1("to_berr_5", t_bus_error, 1'b1); chk1("to_idle", t_mem_req_valid, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        @(negedge clk); chk1("to_berr_sticky", t_bus_error, 1'b1); chk1("main_berr_sticky", bus_error, 1'b1);
        tick(); reset = 1;
        tick(); reset = 0;
        @(negedge clk); chk1("to_berr_cleared", t_bus_error, 1'b0); chk1("main_berr_cleared", bus_error, 1'b0);

        // Reset while waiting for a response
        tick(); imem_req_valid = 1; imem_req_addr = 32'h500;
        tick(); mem_req_ready = 1;
        tick(); mem_req_ready = 0; reset = 1;
        @(negedge clk); chk1("rstw_iresp_wait", imem_resp_valid, 1'b0);
        tick(); reset = 0; mem_resp_valid = 1; mem_resp_data = 32'h5555; imem_req_valid = 0;
        @(negedge clk); chk1("rstw_iresp", imem_resp_valid, 1'b0); chk1("rstw_dresp", dmem_resp_valid, 1'b0);
        chk1("rstw_reqv", mem_req_valid, 1'b0);
        tick(); mem_resp_valid = 0;
        @(negedge clk); chk1("rstw_reqv_after", mem_req_valid, 1'b0);
        tick(); tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
